// File: rtl/seven_seg_scroller.sv
// Multi-digit 7-segment message engine: glyph stream in, static or scrolling active-low segments out.
// Optional blink overlay is compiled in with `define BLINK_DISPLAY_EN.
module seven_seg_scroller #(
    parameter int NUM_DIGITS   = 6,
    parameter int DEPTH        = 16,
    parameter int STEP_CYCLES  = 25000000,
    parameter int BLINK_CYCLES = 12500000
) (
    input  logic                    clock_i,
    input  logic                    resetn_i,
    input  logic                    mode_i,
    input  logic                    clear_i,
    input  logic                    msg_valid_i,
    output logic                    msg_ready_o,
    input  logic [4:0]              msg_code_i,
    input  logic                    msg_last_i,
    input  logic                    blink_i,
    output logic                    wrapped_o,
    output logic [8*NUM_DIGITS-1:0] hex_o
);

    // state  | meaning
    // S_IDLE | no message, display blank, waiting for first beat
    // S_LOAD | collecting beats into the buffer
    // S_SHOW | message complete, driving digits (static or scrolling)
    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHOW} state_t;

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LW = $clog2(DEPTH + 1);
    localparam int SW = 7;
    localparam int CW = $clog2(STEP_CYCLES);

    state_t                  state_q, state_d;
    logic [LW-1:0]           wr_ptr_q, wr_ptr_d;
    logic [LW-1:0]           len_q, len_d;
    logic [LW-1:0]           offset_q, offset_d;
    logic [CW-1:0]           step_q, step_d;
    logic                    wrapped_q, wrapped_d;
    logic                    mode_q;
    logic [8*NUM_DIGITS-1:0] hex_q, hex_d;
    logic [4:0]              buf_q [0:DEPTH-1];

    logic          accept;
    logic          beat_last;
    logic          scroll_en;
    logic          mode_change;
    logic          blink_blank;
    logic [SW-1:0] pos;

    function automatic logic [7:0] glyph(input logic [4:0] c);
        case (c)
            5'd0:    glyph = 8'h03;
            5'd1:    glyph = 8'h9F;
            5'd2:    glyph = 8'h25;
            5'd3:    glyph = 8'h0D;
            5'd4:    glyph = 8'h99;
            5'd5:    glyph = 8'h49;
            5'd6:    glyph = 8'h41;
            5'd7:    glyph = 8'h1F;
            5'd8:    glyph = 8'h01;
            5'd9:    glyph = 8'h09;
            5'd11:   glyph = 8'h49;
            5'd12:   glyph = 8'hE1;
            5'd13:   glyph = 8'h11;
            5'd14:   glyph = 8'hF5;
            5'd15:   glyph = 8'h85;
            5'd16:   glyph = 8'hC5;
            5'd17:   glyph = 8'hD5;
            5'd18:   glyph = 8'h21;
            5'd19:   glyph = 8'hFD;
            5'd20:   glyph = 8'hED;
            5'd21:   glyph = 8'hE3;
            default: glyph = 8'hFF;
        endcase
    endfunction

    assign accept      = msg_valid_i & msg_ready_o;
    assign beat_last   = msg_last_i | (wr_ptr_q == LW'(DEPTH - 1));
    assign scroll_en   = (state_q == S_SHOW) && mode_i && (SW'(len_q) > SW'(NUM_DIGITS));
    assign mode_change = (state_q == S_SHOW) && (mode_i != mode_q);
    assign wrapped_o   = wrapped_q;
    assign hex_o       = hex_q;

    always_ff @(posedge clock_i or negedge resetn_i) begin
        if (!resetn_i) begin
            state_q   <= S_IDLE;
            wr_ptr_q  <= '0;
            len_q     <= '0;
            offset_q  <= '0;
            step_q    <= '0;
            wrapped_q <= 1'b0;
            mode_q    <= 1'b0;
            hex_q     <= '1;
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            len_q     <= len_d;
            offset_q  <= offset_d;
            step_q    <= step_d;
            wrapped_q <= wrapped_d;
            mode_q    <= mode_i;
            hex_q     <= hex_d;
        end
    end

    // Buffer contents are only meaningful below len_q, so no reset is needed.
    always_ff @(posedge clock_i) begin
        if (accept && !clear_i) begin
            buf_q[wr_ptr_q[AW-1:0]] <= msg_code_i;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_LOAD: if (accept) state_d = beat_last ? S_SHOW : S_LOAD;
            S_SHOW:         state_d = S_SHOW;
            default:        state_d = S_IDLE;
        endcase
        if (clear_i) state_d = S_IDLE;
    end

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        len_d     = len_q;
        offset_d  = offset_q;
        step_d    = step_q;
        wrapped_d = 1'b0;
        if (accept) begin
            if (beat_last) begin
                len_d    = wr_ptr_q + LW'(1);
                offset_d = '0;
                step_d   = '0;
            end else begin
                wr_ptr_d = wr_ptr_q + LW'(1);
            end
        end
        if (mode_change) begin
            offset_d = '0;
            step_d   = '0;
        end else if (scroll_en) begin
            if (step_q == CW'(STEP_CYCLES - 1)) begin
                step_d = '0;
                if (offset_q == len_q - LW'(1)) begin
                    offset_d  = '0;
                    wrapped_d = 1'b1;
                end else begin
                    offset_d = offset_q + LW'(1);
                end
            end else begin
                step_d = step_q + CW'(1);
            end
        end
        if (clear_i) begin
            wr_ptr_d  = '0;
            len_d     = '0;
            offset_d  = '0;
            step_d    = '0;
            wrapped_d = 1'b0;
        end
    end

    // Clear blanks the display on the same edge that returns the FSM to idle.
    always_comb begin
        msg_ready_o = (state_q != S_SHOW);
        hex_d       = '1;
        pos         = '0;
        if (state_q == S_SHOW && !blink_blank && !clear_i) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (scroll_en) begin
                    pos = SW'(offset_q) + SW'(i);
                    if (pos >= SW'(len_q)) pos = pos - SW'(len_q);
                    hex_d[8*(NUM_DIGITS-i)-1 -: 8] = glyph(buf_q[pos[AW-1:0]]);
                end else if (SW'(i) < SW'(len_q)) begin
                    hex_d[8*(NUM_DIGITS-i)-1 -: 8] = glyph(buf_q[AW'(i)]);
                end
            end
        end
    end

`ifdef BLINK_DISPLAY_EN
    localparam int BW = $clog2(BLINK_CYCLES + 1);
    logic [BW-1:0] blink_cnt_q;
    logic          blink_ph_q;

    always_ff @(posedge clock_i or negedge resetn_i) begin
        if (!resetn_i) begin
            blink_cnt_q <= '0;
            blink_ph_q  <= 1'b0;
        end else if (state_q == S_SHOW && blink_i && !clear_i) begin
            if (blink_cnt_q == BW'(BLINK_CYCLES - 1)) begin
                blink_cnt_q <= '0;
                blink_ph_q  <= ~blink_ph_q;
            end else begin
                blink_cnt_q <= blink_cnt_q + BW'(1);
            end
        end else begin
            blink_cnt_q <= '0;
            blink_ph_q  <= 1'b0;
        end
    end

    assign blink_blank = blink_i & blink_ph_q;
`else
    logic unused_blink;
    assign unused_blink = blink_i | (BLINK_CYCLES < 0);
    assign blink_blank  = 1'b0;
`endif

endmodule
